// File: rtl/btn_debounce.sv
// btn_debounce: synchronises, debounces and conflict-masks four raw push-buttons,
// producing level outputs plus one-cycle press pulses for jump and down.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 650_000,
   parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_left,
   input  logic btn_right,
   input  logic btn_up,
   input  logic btn_down,
   output logic stepleft,
   output logic stepright,
   output logic stepjump,
   output logic buttondown,
   output logic jump_press,
   output logic down_press
);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   // channel order in every vector: 0 left, 1 right, 2 up, 3 down
   logic [3:0] pad, s1_q, s2_q, stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q [4];
   logic [CNT_W-1:0] cnt_d [4];
   logic jump_press_q, down_press_q;
   assign pad = {btn_down, btn_up, btn_right, btn_left};
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         stable_d[i] = stable_q[i];
         cnt_d[i] = '0;
         if (s2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_MAX) stable_d[i] = s2_q[i];
            else cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q <= '0;
         s2_q <= '0;
         stable_q <= '0;
         jump_press_q <= 1'b0;
         down_press_q <= 1'b0;
         for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      end else begin
         s1_q <= pad;
         s2_q <= s1_q;
         stable_q <= stable_d;
         jump_press_q <= stable_d[2] & ~stable_q[2];
         down_press_q <= stable_d[3] & ~stable_q[3];
         for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      end
   end
   assign stepleft = stable_q[0] & ~stable_q[1];
   assign stepright = stable_q[1] & ~stable_q[0];
   assign stepjump = stable_q[2];
   assign buttondown = stable_q[3];
   assign jump_press = jump_press_q;
   assign down_press = down_press_q;
endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed and random stimulus against a sample-window reference model.
`timescale 1ns/1ps
module tb_btn_debounce;
   localparam int D = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [3:0] pads = 4'h0;
   logic stepleft, stepright, stepjump, buttondown, jump_press, down_press;
   int errors = 0;
   int checks = 0;
   // model: pad samples since reset, newest first, plus accepted levels
   logic [3:0] hist [D+2];
   logic [3:0] st_m = 4'h0;
   logic jp_m = 1'b0;
   logic dp_m = 1'b0;

   btn_debounce #(.DEBOUNCE_CYCLES(D)) dut (
      .clk(clk), .rst(rst),
      .btn_left(pads[0]), .btn_right(pads[1]), .btn_up(pads[2]), .btn_down(pads[3]),
      .stepleft(stepleft), .stepright(stepright), .stepjump(stepjump),
      .buttondown(buttondown), .jump_press(jump_press), .down_press(down_press)
   );

   always #7.692 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr_model;
      for (int k = 0; k < D + 2; k++) hist[k] = 4'h0;
      st_m = 4'h0;
      jp_m = 1'b0;
      dp_m = 1'b0;
   endtask

   // a level flips once the D samples seen by the debouncer (taken 2..D+1 edges ago)
   // all disagree with the currently accepted level
   task automatic model_step;
      logic [3:0] old;
      bit all_diff;
      old = st_m;
      for (int k = D + 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = pads;
      for (int ch = 0; ch < 4; ch++) begin
         all_diff = 1'b1;
         for (int k = 2; k <= D + 1; k++) if (hist[k][ch] == old[ch]) all_diff = 1'b0;
         if (all_diff) st_m[ch] = ~old[ch];
      end
      jp_m = st_m[2] & ~old[2];
      dp_m = st_m[3] & ~old[3];
   endtask

   task automatic tick;
      @(posedge clk);
      if (rst) model_step();
      #1;
      chk("stepleft", stepleft, st_m[0] & ~st_m[1]);
      chk("stepright", stepright, st_m[1] & ~st_m[0]);
      chk("stepjump", stepjump, st_m[2]);
      chk("buttondown", buttondown, st_m[3]);
      chk("jump_press", jump_press, jp_m);
      chk("down_press", down_press, dp_m);
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      int found;
      int npulse;
      logic [7:0] pat;
      clr_model();
      // reset with every pad held
      pads = 4'hF;
      #3 rst = 1'b0;
      #1 chk("rst_async_outs", {stepleft, stepright, stepjump, buttondown, jump_press, down_press}, 6'h0);
      ticks(3);
      @(posedge clk);
      #1 rst = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (c == 5) chk("rst_rel_early", {stepjump, buttondown}, 2'b00);
         if (c == 6) chk("rst_rel_lvl", {stepjump, buttondown, jump_press, down_press}, 4'hF);
         if (c == 6) chk("rst_rel_lr", {stepleft, stepright}, 2'b00);
         if (c == 7) chk("rst_rel_pulse_end", {jump_press, down_press}, 2'b00);
      end
      // clean press and release of up
      pads = 4'h0;
      ticks(10);
      pads[2] = 1'b1;
      npulse = 0;
      for (int c = 1; c <= 30; c++) begin
         tick();
         npulse += int'(jump_press);
         if (c == 5) chk("up_rise_early", stepjump, 1'b0);
         if (c == 6) chk("up_rise", {stepjump, jump_press}, 2'b11);
         if (c == 25) chk("up_fall_early", stepjump, 1'b1);
         if (c == 26) chk("up_fall", {stepjump, jump_press}, 2'b00);
         if (c == 20) pads[2] = 1'b0;
      end
      chk("up_pulse_count", npulse, 1);
      // bouncing down pad
      pat = 8'b1111_0111;
      npulse = 0;
      found = -1;
      for (int c = 0; c < 16; c++) begin
         pads[3] = (c < 8) ? pat[c] : 1'b1;
         tick();
         npulse += int'(down_press);
         if (buttondown && found < 0) found = c + 1;
      end
      chk("bounce_accept_edge", found, 10);
      chk("bounce_pulse_count", npulse, 1);
      pads[3] = 1'b0;
      ticks(8);
      // left/right conflict
      pads[0] = 1'b1;
      ticks(8);
      chk("conf_left_only", {stepleft, stepright}, 2'b10);
      pads[1] = 1'b1;
      ticks(8);
      chk("conf_both", {stepleft, stepright}, 2'b00);
      pads[0] = 1'b0;
      found = -1;
      for (int c = 1; c <= 20 && found < 0; c++) begin
         tick();
         if (stepright) found = c;
      end
      chk("conf_release_edge", found, 6);
      pads[1] = 1'b0;
      ticks(8);
      // reset mid-count on right, with up already accepted
      pads[2] = 1'b1;
      ticks(8);
      pads[1] = 1'b1;
      ticks(5);
      rst = 1'b0;
      clr_model();
      #1 chk("midrst_async", {stepjump, stepright}, 2'b00);
      ticks(2);
      @(posedge clk);
      #1 rst = 1'b1;
      found = -1;
      for (int c = 1; c <= 20 && found < 0; c++) begin
         tick();
         if (stepright) found = c;
      end
      chk("midrst_accept_edge", found, 6);
      // simultaneous rise on all pads
      pads = 4'h0;
      ticks(10);
      pads = 4'hF;
      found = -1;
      for (int c = 1; c <= 20 && found < 0; c++) begin
         tick();
         if (stepjump) begin
            found = c;
            chk("simul_outs", {stepleft, stepright, stepjump, buttondown, jump_press, down_press}, 6'b001111);
         end
      end
      chk("simul_edge", found, 6);
      // random toggling against the model
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < 4; i++) if ($urandom_range(2) == 0) pads[i] = ~pads[i];
         tick();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
